// File: rtl/cgra_axil_pkg.sv
// Shared AXI4-Lite definitions: response codes, channel FSM states and the
// captured write-data payload, reusable by any AXI4-Lite slave in the CGRA.
package cgra_axil_pkg;

  localparam int unsigned AXIL_DATA_W = 32;
  localparam int unsigned AXIL_STRB_W = AXIL_DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } w_state_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  typedef struct packed {
    logic [AXIL_DATA_W-1:0] data;
    logic [AXIL_STRB_W-1:0] strb;
  } axil_w_t;

endpackage

// File: rtl/cgra_axil_sram_slave_if.sv
// AXI4-Lite bus between the CGRA DMA master and the SRAM slave.
interface cgra_axil_sram_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/cgra_sram_1r1w.sv
// Word-organised SRAM: one synchronous read port, one byte-enabled synchronous
// write port. A same-edge read of the word being written returns old contents.
module cgra_sram_1r1w #(
  parameter int unsigned WORDS = 1024,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX_W = $clog2(WORDS)
) (
  input  logic               clk,
  input  logic               re_i,
  input  logic [IDX_W-1:0]   raddr_i,
  output logic [WIDTH-1:0]   rdata_o,
  input  logic               we_i,
  input  logic [IDX_W-1:0]   waddr_i,
  input  logic [WIDTH-1:0]   wdata_i,
  input  logic [WIDTH/8-1:0] wstrb_i
);
  logic [WIDTH-1:0] mem_q [WORDS];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < int'(WIDTH / 8); b++) begin
        if (wstrb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Output register holds its value until the next read is issued.
  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/cgra_axil_sram_slave.sv
// AXI4-Lite slave fronting an on-chip SRAM; independent read and write
// channels, each with a single outstanding transaction.
module cgra_axil_sram_slave
  import cgra_axil_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  cgra_axil_sram_slave_if.slave   s_axi
);
  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
  localparam int unsigned MEM_BYTES = MEM_WORDS * 4;

  w_state_e              w_state_q, w_state_d;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  axil_w_t               wpay_q, wpay_d, w_live, w_sel;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;

  r_state_e              r_state_q, r_state_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic                  rd_ok_q, rd_ok_d;
  logic [1:0]            rresp_q, rresp_d;

  logic                  aw_hs, w_hs, ar_hs, commit, aw_ok, ar_ok;
  logic [ADDR_WIDTH-1:0] aw_sel, aw_off, ar_off;
  logic [DATA_WIDTH-1:0] sram_rdata;

  assign aw_hs  = s_axi.awvalid && awready_q;
  assign w_hs   = s_axi.wvalid && wready_q;
  assign ar_hs  = s_axi.arvalid && arready_q;
  assign w_live = '{data: s_axi.wdata, strb: s_axi.wstrb};

  // Address/data come from the held copy if captured earlier, else the live bus.
  assign aw_sel = aw_held_q ? awaddr_q : s_axi.awaddr;
  assign w_sel  = w_held_q ? wpay_q : w_live;
  assign aw_off = aw_sel - BASE_ADDR;
  assign ar_off = s_axi.araddr - BASE_ADDR;
  assign aw_ok  = aw_off < ADDR_WIDTH'(MEM_BYTES);
  assign ar_ok  = ar_off < ADDR_WIDTH'(MEM_BYTES);
  assign commit = (w_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);

  cgra_sram_1r1w #(.WORDS(MEM_WORDS), .WIDTH(DATA_WIDTH), .IDX_W(IDX_W)) u_sram (
    .clk     (clk),
    .re_i    (ar_hs),
    .raddr_i (ar_off[IDX_W+1:2]),
    .rdata_o (sram_rdata),
    .we_i    (commit && aw_ok),
    .waddr_i (aw_off[IDX_W+1:2]),
    .wdata_i (w_sel.data),
    .wstrb_i (w_sel.strb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wpay_q    <= '0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rd_ok_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wpay_q    <= wpay_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rd_ok_q   <= rd_ok_d;
      rresp_q   <= rresp_d;
    end
  end

  // Write channel: capture AW and W in any order, commit when both are present.
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wpay_d    = wpay_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_axi.awaddr;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wpay_d   = w_live;
        end
        if (commit) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          bresp_d   = aw_ok ? RESP_OKAY : RESP_DECERR;
        end
      end
      W_RESP: begin
        if (s_axi.bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) && !aw_held_d;
    wready_d  = (w_state_d == W_IDLE) && !w_held_d;
  end

  // Read channel: one registered response per AR handshake.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rd_ok_d   = rd_ok_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_DATA;
          rvalid_d  = 1'b1;
          rd_ok_d   = ar_ok;
          rresp_d   = ar_ok ? RESP_OKAY : RESP_DECERR;
        end
      end
      R_DATA: begin
        if (s_axi.rready) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rd_ok_q ? sram_rdata : '0;
endmodule
